// File: rtl/e203_ifu_ir_align_pkg.sv
// Shared definitions for the IFU instruction realigner: instruction/PC sizes,
// the RUN/ERR_HOLD state encoding and the 32-bit opcode test.
package e203_ifu_ir_align_pkg;

    localparam int E203_INSTR_SIZE = 32;
    localparam int E203_PC_SIZE    = 32;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_ERR_HOLD = 1'b1
    } ir_align_state_e;

    // RV32 base instructions have opcode bits [1:0] == 2'b11; anything else is RVC.
    function automatic logic is_rv32_op(input logic [1:0] op);
        return (op == 2'b11);
    endfunction

endpackage

// File: rtl/e203_ifu_ir_align.sv
// Instruction realigner between the fetch response and the IR stage.
// Word-aligned 32-bit fetch words are split/joined into whole RV32/RVC
// instructions; one leftover halfword is buffered and the output is registered.
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high; valid never waits on ready, and the ir_* payload is held stable while
// o_ir_valid is high and i_ir_ready is low.
// Optional feature: define E203_IR_ALIGN_RVC_EN to enable compressed-instruction
// support; without it every word is emitted as a 32-bit instruction.
module e203_ifu_ir_align
    import e203_ifu_ir_align_pkg::*;
#(
    parameter int PC_W = E203_PC_SIZE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_rsp_valid,
    output logic                       o_rsp_ready,
    input  logic [31:0]                i_rsp_rdata,
    input  logic                       i_rsp_err,
    input  logic                       i_flush_req,
    input  logic [PC_W-1:0]            i_flush_pc,
    output logic                       o_ir_valid,
    input  logic                       i_ir_ready,
    output logic [E203_INSTR_SIZE-1:0] o_ir_instr,
    output logic [PC_W-1:0]            o_ir_pc,
    output logic                       o_ir_rv32,
    output logic                       o_ir_err,
    output logic                       o_dbg_state
);

    ir_align_state_e             r_state;
    ir_align_state_e             w_state_nxt;
    logic                        r_ir_valid;
    logic [E203_INSTR_SIZE-1:0]  r_ir_instr;
    logic [PC_W-1:0]             r_ir_pc;
    logic                        r_ir_rv32;
    logic                        r_ir_err;
    logic [PC_W-1:0]             r_next_pc;

    logic                        w_out_en;
    logic                        w_rsp_ready;
    logic                        w_emit;
    logic [E203_INSTR_SIZE-1:0]  w_emit_instr;
    logic                        w_emit_rv32;
    logic                        w_emit_err;
    logic                        w_err_take;

`ifdef E203_IR_ALIGN_RVC_EN
    logic [15:0]                 r_lo_hw;
    logic [15:0]                 w_lo_hw_nxt;
    logic                        r_lo_vld;
    logic                        w_lo_vld_nxt;
    logic                        r_skip;
    logic                        w_skip_nxt;
    logic                        w_unused_flush_lsb;
    // Halfword alignment only: bit0 of a redirect target carries no meaning.
    assign w_unused_flush_lsb = i_flush_pc[0];
`else
    logic                        w_unused_flush_lsb;
    // Without RVC every redirect target is treated as word-aligned.
    assign w_unused_flush_lsb = ^i_flush_pc[1:0];
`endif

    // The output slot can take a new instruction when empty or being drained.
    assign w_out_en    = !r_ir_valid | i_ir_ready;
    assign o_rsp_ready = w_rsp_ready & rst_n;
    assign o_ir_valid  = r_ir_valid;
    assign o_ir_instr  = r_ir_instr;
    assign o_ir_pc     = r_ir_pc;
    assign o_ir_rv32   = r_ir_rv32;
    assign o_ir_err    = r_ir_err;
    assign o_dbg_state = r_state;

    // State register: RUN normally, ERR_HOLD after a bus error until redirected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // Next state: flush always returns to RUN; an accepted error word parks us.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush_req)     w_state_nxt = ST_RUN;
        else if (w_err_take) w_state_nxt = ST_ERR_HOLD;
    end

    // Assembly decisions: what to emit, whether the word is consumed, buffer updates.
    always_comb begin
        w_rsp_ready  = 1'b0;
        w_emit       = 1'b0;
        w_emit_instr = '0;
        w_emit_rv32  = 1'b0;
        w_emit_err   = 1'b0;
        w_err_take   = 1'b0;
`ifdef E203_IR_ALIGN_RVC_EN
        w_lo_hw_nxt  = r_lo_hw;
        w_lo_vld_nxt = r_lo_vld;
        w_skip_nxt   = r_skip;
`endif
        if (!i_flush_req && w_out_en) begin
            if (r_state == ST_ERR_HOLD) begin
                w_rsp_ready = 1'b1;
            end else begin
`ifdef E203_IR_ALIGN_RVC_EN
                if (r_lo_vld && !is_rv32_op(r_lo_hw[1:0])) begin
                    // Buffered halfword is a complete RVC instruction.
                    w_emit       = 1'b1;
                    w_emit_instr = {16'h0, r_lo_hw};
                    w_lo_vld_nxt = 1'b0;
                end else if (i_rsp_valid) begin
                    w_rsp_ready = 1'b1;
                    if (i_rsp_err) begin
                        w_err_take = 1'b1;
                    end else if (r_lo_vld) begin
                        // Second half of a straddling 32-bit instruction.
                        w_emit       = 1'b1;
                        w_emit_rv32  = 1'b1;
                        w_emit_instr = {i_rsp_rdata[15:0], r_lo_hw};
                        w_lo_hw_nxt  = i_rsp_rdata[31:16];
                        w_lo_vld_nxt = 1'b1;
                    end else if (r_skip) begin
                        // Redirect landed on the upper halfword.
                        w_skip_nxt = 1'b0;
                        if (!is_rv32_op(i_rsp_rdata[17:16])) begin
                            w_emit       = 1'b1;
                            w_emit_instr = {16'h0, i_rsp_rdata[31:16]};
                        end else begin
                            w_lo_hw_nxt  = i_rsp_rdata[31:16];
                            w_lo_vld_nxt = 1'b1;
                        end
                    end else if (is_rv32_op(i_rsp_rdata[1:0])) begin
                        w_emit       = 1'b1;
                        w_emit_rv32  = 1'b1;
                        w_emit_instr = i_rsp_rdata;
                    end else begin
                        w_emit       = 1'b1;
                        w_emit_instr = {16'h0, i_rsp_rdata[15:0]};
                        w_lo_hw_nxt  = i_rsp_rdata[31:16];
                        w_lo_vld_nxt = 1'b1;
                    end
                end
`else
                if (i_rsp_valid) begin
                    w_rsp_ready = 1'b1;
                    if (i_rsp_err) begin
                        w_err_take = 1'b1;
                    end else begin
                        w_emit       = 1'b1;
                        w_emit_rv32  = 1'b1;
                        w_emit_instr = i_rsp_rdata;
                    end
                end
`endif
                if (w_err_take) begin
                    // Error instruction: zero payload, flagged, buffer discarded.
                    w_emit       = 1'b1;
                    w_emit_rv32  = 1'b1;
                    w_emit_err   = 1'b1;
                    w_emit_instr = '0;
`ifdef E203_IR_ALIGN_RVC_EN
                    w_lo_vld_nxt = 1'b0;
                    w_skip_nxt   = 1'b0;
`endif
                end
            end
        end
    end

    // Output registers: load only when the slot is free; flush kills the valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_valid <= 1'b0;
            r_ir_instr <= '0;
            r_ir_pc    <= '0;
            r_ir_rv32  <= 1'b0;
            r_ir_err   <= 1'b0;
        end else if (i_flush_req) begin
            r_ir_valid <= 1'b0;
        end else if (w_out_en) begin
            r_ir_valid <= w_emit;
            if (w_emit) begin
                r_ir_instr <= w_emit_instr;
                r_ir_pc    <= r_next_pc;
                r_ir_rv32  <= w_emit_rv32;
                r_ir_err   <= w_emit_err;
            end
        end
    end

    // PC of the next halfword to be emitted; reloaded on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_pc <= '0;
        end else if (i_flush_req) begin
`ifdef E203_IR_ALIGN_RVC_EN
            r_next_pc <= {i_flush_pc[PC_W-1:1], 1'b0};
`else
            r_next_pc <= {i_flush_pc[PC_W-1:2], 2'b00};
`endif
        end else if (w_emit) begin
            r_next_pc <= r_next_pc + (w_emit_rv32 ? PC_W'(4) : PC_W'(2));
        end
    end

`ifdef E203_IR_ALIGN_RVC_EN
    // Leftover halfword and skip flag; a redirect to an odd halfword sets skip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo_hw  <= '0;
            r_lo_vld <= 1'b0;
            r_skip   <= 1'b0;
        end else if (i_flush_req) begin
            r_lo_vld <= 1'b0;
            r_skip   <= i_flush_pc[1];
        end else if (w_out_en) begin
            r_lo_hw  <= w_lo_hw_nxt;
            r_lo_vld <= w_lo_vld_nxt;
            r_skip   <= w_skip_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_e203_ifu_ir_align.sv
// Scoreboard bench for e203_ifu_ir_align. Expectations follow the build: with
// E203_IR_ALIGN_RVC_EN defined the RVC split/join results are expected, otherwise
// every word is expected as one 32-bit instruction on a word-aligned PC.
module tb_e203_ifu_ir_align;

    logic        clk;
    logic        rst_n;
    logic        i_rsp_valid;
    logic        o_rsp_ready;
    logic [31:0] i_rsp_rdata;
    logic        i_rsp_err;
    logic        i_flush_req;
    logic [31:0] i_flush_pc;
    logic        o_ir_valid;
    logic        i_ir_ready;
    logic [31:0] o_ir_instr;
    logic [31:0] o_ir_pc;
    logic        o_ir_rv32;
    logic        o_ir_err;
    logic        o_dbg_state;

    int          checks;
    int          errors;
    logic [65:0] exp_q[$];

    e203_ifu_ir_align dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rsp_valid (i_rsp_valid),
        .o_rsp_ready (o_rsp_ready),
        .i_rsp_rdata (i_rsp_rdata),
        .i_rsp_err   (i_rsp_err),
        .i_flush_req (i_flush_req),
        .i_flush_pc  (i_flush_pc),
        .o_ir_valid  (o_ir_valid),
        .i_ir_ready  (i_ir_ready),
        .o_ir_instr  (o_ir_instr),
        .o_ir_pc     (o_ir_pc),
        .o_ir_rv32   (o_ir_rv32),
        .o_ir_err    (o_ir_err),
        .o_dbg_state (o_dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc,
                            input logic rv32, input logic err);
        exp_q.push_back({instr, pc, rv32, err});
    endtask

    // Monitor: every IR handshake pops one expected instruction.
    always @(negedge clk) begin
        if (rst_n && o_ir_valid && i_ir_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ir_unexpected act=instr %h pc %h rv32 %0d err %0d exp=none",
                         o_ir_instr, o_ir_pc, o_ir_rv32, o_ir_err);
            end else begin
                logic [65:0] e;
                e = exp_q.pop_front();
                if ({o_ir_instr, o_ir_pc, o_ir_rv32, o_ir_err} !== e) begin
                    errors++;
                    $display("FAIL ir_out act=instr %h pc %h rv32 %0d err %0d exp=instr %h pc %h rv32 %0d err %0d",
                             o_ir_instr, o_ir_pc, o_ir_rv32, o_ir_err,
                             e[65:34], e[33:2], e[1], e[0]);
                end
            end
        end
    end

    // Driver: present one word until accepted (called just after a rising edge).
    task automatic send_word(input logic [31:0] data, input logic err);
        logic acc;
        acc = 1'b0;
        i_rsp_valid = 1'b1;
        i_rsp_rdata = data;
        i_rsp_err   = err;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            if (o_rsp_ready) acc = 1'b1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL rsp_accept act=timeout exp=accepted word %h", data);
        end else begin
            @(posedge clk);
            #1;
        end
        i_rsp_valid = 1'b0;
        i_rsp_err   = 1'b0;
    endtask

    task automatic flush(input logic [31:0] pc);
        i_flush_req = 1'b1;
        i_flush_pc  = pc;
        @(posedge clk);
        #1;
        i_flush_req = 1'b0;
    endtask

    // Wait for every expected instruction to be observed, bounded.
    task automatic drain(input string name);
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_%s act=%0d pending exp=0", name, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        i_rsp_valid = 1'b1;
        i_rsp_rdata = 32'h0000_0013;
        i_rsp_err   = 1'b0;
        i_flush_req = 1'b0;
        i_flush_pc  = '0;
        i_ir_ready  = 1'b1;

        // Reset values, with a word offered so rsp_ready must be forced low.
        repeat (2) @(negedge clk);
        check("rst_ir_valid", 32'(o_ir_valid), 32'h0);
        check("rst_ir_instr", o_ir_instr, 32'h0);
        check("rst_ir_pc", o_ir_pc, 32'h0);
        check("rst_ir_rv32", 32'(o_ir_rv32), 32'h0);
        check("rst_ir_err", 32'(o_ir_err), 32'h0);
        check("rst_rsp_ready", 32'(o_rsp_ready), 32'h0);
        check("rst_state", 32'(o_dbg_state), 32'h0);
        i_rsp_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: two plain 32-bit instructions.
        flush(32'h100);
        push_exp(32'h00A0_0093, 32'h100, 1'b1, 1'b0);
        push_exp(32'h00B0_0113, 32'h104, 1'b1, 1'b0);
        send_word(32'h00A0_0093, 1'b0);
        send_word(32'h00B0_0113, 1'b0);
        drain("t1");

        // 2: two RVC instructions in one word.
        flush(32'h200);
`ifdef E203_IR_ALIGN_RVC_EN
        push_exp(32'h0000_4585, 32'h200, 1'b0, 1'b0);
        push_exp(32'h0000_4501, 32'h202, 1'b0, 1'b0);
        send_word(32'h4501_4585, 1'b0);
        i_rsp_valid = 1'b1;
        i_rsp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("t2_rsp_ready_hold", 32'(o_rsp_ready), 32'h0);
        @(posedge clk);
        #1;
        i_rsp_valid = 1'b0;
`else
        push_exp(32'h4501_4585, 32'h200, 1'b1, 1'b0);
        send_word(32'h4501_4585, 1'b0);
`endif
        drain("t2");

        // 3: RVC then a 32-bit instruction straddling two words.
        flush(32'h200);
`ifdef E203_IR_ALIGN_RVC_EN
        push_exp(32'h0000_4585, 32'h200, 1'b0, 1'b0);
        push_exp(32'h00A0_0093, 32'h202, 1'b1, 1'b0);
        push_exp(32'h0000_1234, 32'h206, 1'b0, 1'b0);
`else
        push_exp(32'h0093_4585, 32'h200, 1'b1, 1'b0);
        push_exp(32'h1234_00A0, 32'h204, 1'b1, 1'b0);
`endif
        send_word(32'h0093_4585, 1'b0);
        send_word(32'h1234_00A0, 1'b0);
        drain("t3");

        // 4: redirect to an upper halfword discards the low half.
        flush(32'h302);
`ifdef E203_IR_ALIGN_RVC_EN
        push_exp(32'h0000_4505, 32'h302, 1'b0, 1'b0);
`else
        push_exp(32'h4505_ABCD, 32'h300, 1'b1, 1'b0);
`endif
        send_word(32'h4505_ABCD, 1'b0);
        drain("t4");

        // 7: redirect to an upper halfword that starts a straddling instruction.
        flush(32'h702);
`ifdef E203_IR_ALIGN_RVC_EN
        push_exp(32'h00A0_0093, 32'h702, 1'b1, 1'b0);
        push_exp(32'h0000_1234, 32'h706, 1'b0, 1'b0);
`else
        push_exp(32'h0093_4585, 32'h700, 1'b1, 1'b0);
        push_exp(32'h1234_00A0, 32'h704, 1'b1, 1'b0);
`endif
        send_word(32'h0093_4585, 1'b0);
        send_word(32'h1234_00A0, 1'b0);
        drain("t7");

        // 5: backpressure for 5 cycles with more words offered.
        flush(32'h600);
        push_exp(32'h0010_0093, 32'h600, 1'b1, 1'b0);
        push_exp(32'h0020_0113, 32'h604, 1'b1, 1'b0);
        push_exp(32'h0030_0193, 32'h608, 1'b1, 1'b0);
        i_ir_ready = 1'b0;
        send_word(32'h0010_0093, 1'b0);
        i_rsp_valid = 1'b1;
        i_rsp_rdata = 32'h0020_0113;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_stall_rsp_ready", 32'(o_rsp_ready), 32'h0);
            check("t5_stall_ir_valid", 32'(o_ir_valid), 32'h1);
            check("t5_stall_ir_instr", o_ir_instr, 32'h0010_0093);
            check("t5_stall_ir_pc", o_ir_pc, 32'h600);
        end
        @(posedge clk);
        #1;
        i_ir_ready = 1'b1;
        send_word(32'h0020_0113, 1'b0);
        send_word(32'h0030_0193, 1'b0);
        drain("t5");

        // 6: bus error, later words dropped, flush recovers.
        flush(32'h400);
        push_exp(32'h0, 32'h400, 1'b1, 1'b1);
        send_word(32'h0050_0293, 1'b1);
        send_word(32'h0060_0313, 1'b0);
        send_word(32'h0070_0393, 1'b0);
        drain("t6_err");
        @(negedge clk);
        check("t6_state_err_hold", 32'(o_dbg_state), 32'h1);
        @(posedge clk);
        #1;
        flush(32'h500);
        @(negedge clk);
        check("t6_state_run", 32'(o_dbg_state), 32'h0);
        @(posedge clk);
        #1;
        push_exp(32'h00A0_0093, 32'h500, 1'b1, 1'b0);
        send_word(32'h00A0_0093, 1'b0);
        // Flush in the same cycle as an IR handshake: instruction counts as taken.
        flush(32'h504);
        @(negedge clk);
        check("t6_flush_clears_valid", 32'(o_ir_valid), 32'h0);
        @(posedge clk);
        #1;
        push_exp(32'h00B0_0113, 32'h504, 1'b1, 1'b0);
        send_word(32'h00B0_0113, 1'b0);
        drain("t6_resume");

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
